pipe_adder: RTL and testbench

Pipelined, parametrised signed adder: computes S = A + B + ci for N-bit operands split into STAGES equal carry-chained chunks, one chunk per pipeline stage, with a valid/ready handshake on both sides. It is the throughput-oriented successor to the combinational n-bit adder and sits in datapaths where a full-width carry chain cannot close timing in one cycle. It adds stall/backpressure, a signed-overflow flag and optional saturation.

---
 rtl/pipe_adder_pkg.sv | 32 +++
 rtl/pipe_adder_stage.sv | 39 +++
 rtl/pipe_adder.sv | 139 +++++++++++++
 tb/tb_pipe_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared sizing helpers and saturation constants for pipe_adder.
// Saturation constants are only consumed when PIPE_ADDER_SAT_EN is defined.
package pipe_adder_pkg;

    localparam int PA_MAX_N = 256;

    function automatic int chunk_width(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit stages_divide(input int n, input int stages);
        return (stages > 0) && ((n % stages) == 0);
    endfunction

    // Constant-width results; callers cast down to their own N.
    function automatic logic [PA_MAX_N-1:0] sat_max(input int n);
        logic [PA_MAX_N-1:0] result;
        result = '0;
        for (int i = 0; i < n - 1; i++) begin
            result[i] = 1'b1;
        end
        return result;
    endfunction

    function automatic logic [PA_MAX_N-1:0] sat_min(input int n);
        logic [PA_MAX_N-1:0] result;
        result = '0;
        result[n-1] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// adder_stage: one W-bit chunk of the carry-chained pipeline.
// The chunk sum is combinational; carry and valid are registered and frozen while disabled.
module adder_stage
#(
    parameter int W = 8
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_enable,
    input  logic         i_valid,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_carry,
    output logic [W-1:0] o_sum,
    output logic         o_carry,
    output logic         o_valid
);

    logic [W:0] w_total;
    logic       r_carry;
    logic       r_valid;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_carry};
    assign o_sum   = w_total[W-1:0];
    assign o_carry = r_carry;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_enable) begin
            r_carry <= w_total[W];
            r_valid <= i_valid;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined signed adder, one W-bit carry-chained chunk per stage, global stall.
// Optional saturation on signed overflow is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         co,
    output logic         ovf
);

    localparam int W = chunk_width(N, STAGES);

    if (!stages_divide(N, STAGES)) begin : g_badConfig
        $error("pipe_adder: N must be a non-zero multiple of STAGES");
    end

    logic         w_stall;
    logic         w_enable;
    logic         w_lastValid;
    logic         w_lastCarry;
    logic [N-1:0] w_rawSum;
    logic [N-1:0] w_sNext;
    logic         w_signA;
    logic         w_signB;
    logic         w_ovfNext;
    logic [N-1:0] r_s;
    logic         r_ovf;

    assign w_stall  = w_lastValid && !out_ready;
    assign w_enable = !w_stall;

    // Operands shrink by one chunk per stage while finished sum chunks accumulate below.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = N - k * W;

        logic [HI-1:0]        w_aHi;
        logic [HI-1:0]        w_bHi;
        logic                 w_carryIn;
        logic                 w_validIn;
        logic [W-1:0]         w_chunk;
        logic [(k+1)*W-1:0]   w_sumNew;
        logic                 w_carry;
        logic                 w_valid;

        if (k == 0) begin : g_head
            assign w_aHi     = A;
            assign w_bHi     = B;
            assign w_carryIn = ci;
            assign w_validIn = in_valid;
            assign w_sumNew  = w_chunk;
        end else begin : g_tail
            assign w_aHi     = g_stage[k-1].g_pass.r_a;
            assign w_bHi     = g_stage[k-1].g_pass.r_b;
            assign w_carryIn = g_stage[k-1].w_carry;
            assign w_validIn = g_stage[k-1].w_valid;
            assign w_sumNew  = {w_chunk, g_stage[k-1].g_pass.r_sum};
        end

        adder_stage #(
            .W (W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .i_enable (w_enable),
            .i_valid  (w_validIn),
            .i_a      (w_aHi[W-1:0]),
            .i_b      (w_bHi[W-1:0]),
            .i_carry  (w_carryIn),
            .o_sum    (w_chunk),
            .o_carry  (w_carry),
            .o_valid  (w_valid)
        );

        if (k < STAGES - 1) begin : g_pass
            logic [HI-W-1:0]    r_a;
            logic [HI-W-1:0]    r_b;
            logic [(k+1)*W-1:0] r_sum;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sum <= '0;
                end else if (w_enable) begin
                    r_a   <= w_aHi[HI-1:W];
                    r_b   <= w_bHi[HI-1:W];
                    r_sum <= w_sumNew;
                end
            end
        end
    end

    assign w_lastValid = g_stage[STAGES-1].w_valid;
    assign w_lastCarry = g_stage[STAGES-1].w_carry;
    assign w_rawSum    = g_stage[STAGES-1].w_sumNew;
    assign w_signA     = g_stage[STAGES-1].w_aHi[W-1];
    assign w_signB     = g_stage[STAGES-1].w_bHi[W-1];
    assign w_ovfNext   = (w_signA == w_signB) && (w_rawSum[N-1] != w_signA);

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [N-1:0] SAT_MAX = N'(sat_max(N));
    localparam logic [N-1:0] SAT_MIN = N'(sat_min(N));

    assign w_sNext = w_ovfNext ? (w_signA ? SAT_MIN : SAT_MAX) : w_rawSum;
`else
    assign w_sNext = w_rawSum;
`endif

    // Sum and overflow are registered alongside the final stage's carry and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s   <= '0;
            r_ovf <= 1'b0;
        end else if (w_enable) begin
            r_s   <= w_sNext;
            r_ovf <= w_ovfNext;
        end
    end

    assign in_ready  = w_enable;
    assign out_valid = w_lastValid;
    assign co        = w_lastCarry;
    assign S         = r_s;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (N=8, STAGES=4) with directed and random beats.
// Expected results come from integer arithmetic; PIPE_ADDER_SAT_EN selects the saturating model.
module tb_pipe_adder;

    localparam int N      = 8;
    localparam int STAGES = 4;
    localparam int MAXS   = (1 << (N - 1)) - 1;
    localparam int MINS   = -(1 << (N - 1));

    typedef struct {
        logic [N-1:0] s;
        logic         co;
        logic         ovf;
        int           cyc;
        int           stl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;

    exp_t         expQ[$];
    int           checks = 0;
    int           errors = 0;
    int           cycleCnt = 0;
    int           stallCnt = 0;
    int           readyMode = 1;
    bit           pendingHold = 1'b0;
    int           holdCnt = 0;
    bit           prevStall = 1'b0;
    logic [N+1:0] prevOut = '0;

    pipe_adder #(
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (out_valid === 1'b1 && out_ready === 1'b0) stallCnt <= stallCnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Reference: unsigned (N+1)-bit sum gives S/co, signed range check gives ovf.
    function automatic exp_t refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        exp_t e;
        int   usum;
        int   ssum;
        usum  = int'(a) + int'(b) + int'(c);
        ssum  = int'($signed(a)) + int'($signed(b)) + int'(c);
        e.co  = (usum >= (1 << N));
        e.ovf = (ssum > MAXS) || (ssum < MINS);
        e.s   = N'(usum);
`ifdef PIPE_ADDER_SAT_EN
        if (e.ovf) e.s = (ssum > 0) ? N'(MAXS) : N'(MINS);
`endif
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        exp_t e;
        int   guard;
        @(negedge clk);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        ci       = c;
        #1;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: in_ready=%0b after 200 cycles, expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e     = refModel(a, b, c);
            e.cyc = cycleCnt;
            e.stl = stallCnt;
            expQ.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
        end
        idle(2);
    endtask

    // Monitor: owns out_ready, pops the scoreboard on every transfer, checks hold and latency.
    initial begin
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (holdCnt > 0) begin
                out_ready = 1'b0;
                holdCnt--;
            end else if (pendingHold && out_valid === 1'b1) begin
                pendingHold = 1'b0;
                holdCnt     = 2;
                out_ready   = 1'b0;
            end else if (readyMode == 0) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (rst === 1'b1) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall)
                    checkOutput("holdOutputs", 32'({out_valid, co, ovf, S}), 32'({1'b1, prevOut}));
                if (out_valid === 1'b1 && !prevStall && expQ.size() > 0)
                    checkOutput("latency", cycleCnt - expQ[0].cyc, STAGES - 1 + stallCnt - expQ[0].stl);
                if (out_valid === 1'b1 && out_ready === 1'b0)
                    checkOutput("stallInReady", 32'(in_ready), 32'(0));
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedOutput: S=%0h with empty scoreboard, expected no beat", S);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("result{co,ovf,S}", 32'({co, ovf, S}), 32'({e.co, e.ovf, e.s}));
                    end
                end
                prevStall = (out_valid === 1'b1) && (out_ready === 1'b0);
                prevOut   = {co, ovf, S};
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        ci       = 1'b0;

        @(negedge clk);
        checkOutput("resetOutValid", 32'(out_valid), 32'(0));
        checkOutput("resetS", 32'(S), 32'(0));
        checkOutput("resetCo", 32'(co), 32'(0));
        checkOutput("resetOvf", 32'(ovf), 32'(0));
        checkOutput("resetInReady", 32'(in_ready), 32'(1));
        rst = 1'b0;

        readyMode = 1;
        applyStimulus(8'd5, 8'd10, 1'b0);
        applyStimulus(8'd5, 8'd10, 1'b1);
        applyStimulus(8'd30, 8'hF6, 1'b0);
        applyStimulus(8'd127, 8'd1, 1'b0);
        applyStimulus(8'h80, 8'hFF, 1'b0);
        applyStimulus(8'h7F, 8'h00, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        idle(1);
        waitDrain();

        pendingHold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(N'(i * 37 + 3), N'(200 - i * 19), 1'(i));
        end
        idle(1);
        waitDrain();

        applyStimulus(8'd11, 8'd22, 1'b0);
        applyStimulus(8'd33, 8'd44, 1'b1);
        applyStimulus(8'd55, 8'd66, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkOutput("midResetOutValid", 32'(out_valid), 32'(0));
        rst = 1'b0;
        idle(4);
        applyStimulus(8'h40, 8'h3F, 1'b1);
        idle(1);
        waitDrain();

        readyMode = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        readyMode = 1;
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
